// File: rtl/xor_selftest_pkg.sv
// Shared types and constants for the XOR self-test controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package xor_selftest_pkg;

  // Sweep sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Saturation point of the mismatch counter.
  localparam logic [7:0] ERR_MAX = 8'd255;

  // Width of the settle counter; it covers SETTLE values up to 15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/xor_selftest_ctrl_if.sv
// Bundle between the self-test controller and the XOR unit / test host.
// Latency: n/a (wires only).
// Backpressure: none; start is a one-cycle request that is dropped while busy.
interface xor_selftest_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;

  // Controller side.
  modport master (
    input  start, result,
    output a, b, busy, done, pass, err_count
  );

  // Host / XOR-unit side.
  modport slave (
    output start, result,
    input  a, b, busy, done, pass, err_count
  );
endinterface

// File: rtl/my_xor.sv
// Combinational XOR unit exercised by the self-test controller.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module my_xor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_selftest_ctrl.sv
// Exhaustive self-test sweep of an external XOR unit; optional macro XOR_SELFTEST_STOP_ON_FAIL_EN halts at the first mismatch.
// Latency: SETTLE+2 cycles per vector; 2^(2*WIDTH) vectors per full sweep.
// Backpressure: start is accepted only in IDLE/DONE and silently ignored while busy.
module xor_selftest_ctrl
  import xor_selftest_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  xor_selftest_ctrl_if.master bus
);

  localparam int VW = 2 * WIDTH;
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [7:0]        err_q, err_d;

  logic [VW-1:0]     vec_inc;
  logic              mismatch;

  assign vec_inc  = vec_q + 1'b1;
  // The result is only acted on in CHECK, so its value elsewhere is irrelevant.
  assign mismatch = (bus.result != (a_q ^ b_q));

  // Next-state and datapath updates for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // A new sweep always restarts from vector 0 with a clean error count.
          state_d = ST_APPLY;
          vec_d   = '0;
          wait_d  = '0;
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
        end
      end

      ST_APPLY: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end

      ST_WAIT: begin
        if (wait_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end

      ST_CHECK: begin
`ifdef XOR_SELFTEST_STOP_ON_FAIL_EN
        if (mismatch) begin
          // Freeze on the failing vector so a/b identify it while in DONE.
          err_d   = 8'd1;
          state_d = ST_DONE;
        end else if (&vec_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_APPLY;
          vec_d   = vec_inc;
          a_d     = vec_inc[WIDTH-1:0];
          b_d     = vec_inc[VW-1:WIDTH];
        end
`else
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + 8'd1;
        end
        // The all-ones vector is the last one; the counter never wraps to 0.
        if (&vec_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_APPLY;
          vec_d   = vec_inc;
          a_d     = vec_inc[WIDTH-1:0];
          b_d     = vec_inc[VW-1:WIDTH];
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.err_count = err_q;
  assign bus.busy      = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = (state_q == ST_DONE) && (err_q == 8'd0);

endmodule

// File: tb/tb_xor_selftest_ctrl.sv
// Bench for xor_selftest_ctrl: WIDTH=4 and WIDTH=5 controllers, each driving a my_xor with an optional fault overlay.
// Latency: checks full-sweep duration in busy cycles against fixed expectations.
// Backpressure: exercises a start pulse while busy and a mid-sweep reset.
module tb_xor_selftest_ctrl;

  logic clk;
  logic rst_n;
  int   fault_mode;   // 0: correct, 1: result bit0 forced to 0, 2: result constant 0

  xor_selftest_ctrl_if #(.WIDTH(4)) if4 ();
  xor_selftest_ctrl_if #(.WIDTH(5)) if5 ();

  logic [3:0] x4;
  logic [4:0] x5;

  xor_selftest_ctrl #(.WIDTH(4), .SETTLE(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  xor_selftest_ctrl #(.WIDTH(5), .SETTLE(2)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  my_xor #(.WIDTH(4)) u_xor4 (.a(if4.a), .b(if4.b), .y(x4));
  my_xor #(.WIDTH(5)) u_xor5 (.a(if5.a), .b(if5.b), .y(x5));

  assign if4.result = (fault_mode == 0) ? x4 : (fault_mode == 1) ? (x4 & 4'b1110) : 4'd0;
  assign if5.result = (fault_mode == 0) ? x5 : (fault_mode == 1) ? (x5 & 5'b11110) : 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    w5;
    int    mode;
    int    exp_err;
    int    exp_pass;
    int    exp_a;
    int    exp_b;
    int    exp_cycles;
  } sweep_t;

  sweep_t vecs[4];
  sweep_t exp_q[$];

  int tests_run;
  int tests_failed;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sel_busy(input bit w5);
    return w5 ? int'(if5.busy) : int'(if4.busy);
  endfunction

  function automatic int sel_done(input bit w5);
    return w5 ? int'(if5.done) : int'(if4.done);
  endfunction

  task automatic set_start(input bit w5, input logic v);
    if (w5) if5.start = v;
    else    if4.start = v;
  endtask

  // Runs one sweep; extra_start_at > 0 pulses start again at that busy cycle.
  task automatic do_sweep(input sweep_t v, input int extra_start_at);
    sweep_t e;
    int     cyc;
    int     k;
    bit     seen;
    int     act_a, act_b, act_err, act_pass;
    fault_mode = v.mode;
    exp_q.push_back(v);
    @(negedge clk);
    set_start(v.w5, 1'b1);
    @(negedge clk);
    set_start(v.w5, 1'b0);
    cyc  = 0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 6000) begin
      if (sel_done(v.w5) != 0) begin
        seen = 1'b1;
      end else begin
        if (sel_busy(v.w5) != 0) cyc++;
        set_start(v.w5, (extra_start_at > 0 && cyc == extra_start_at) ? 1'b1 : 1'b0);
        @(negedge clk);
        k++;
      end
    end
    set_start(v.w5, 1'b0);
    e = exp_q.pop_front();
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, expected after %0d", e.name, k, e.exp_cycles);
    end else begin
      act_a    = v.w5 ? int'(if5.a) : int'(if4.a);
      act_b    = v.w5 ? int'(if5.b) : int'(if4.b);
      act_err  = v.w5 ? int'(if5.err_count) : int'(if4.err_count);
      act_pass = v.w5 ? int'(if5.pass) : int'(if4.pass);
      chk({e.name, "_cycles"}, cyc, e.exp_cycles);
      chk({e.name, "_err"},    act_err, e.exp_err);
      chk({e.name, "_pass"},   act_pass, e.exp_pass);
      chk({e.name, "_a"},      act_a, e.exp_a);
      chk({e.name, "_b"},      act_b, e.exp_b);
      chk({e.name, "_busy"},   sel_busy(v.w5), 0);
    end
  endtask

  initial begin
    int cyc;
    tests_run    = 0;
    tests_failed = 0;
    fault_mode   = 0;
    if4.start    = 1'b0;
    if5.start    = 1'b0;
    rst_n        = 1'b0;

`ifdef XOR_SELFTEST_STOP_ON_FAIL_EN
    vecs[0] = '{"good4",   1'b0, 0,   0, 1, 15, 15, 1024};
    vecs[1] = '{"bit0_4",  1'b0, 1,   1, 0,  1,  0,    8};
    vecs[2] = '{"zero4",   1'b0, 2,   1, 0,  1,  0,    8};
    vecs[3] = '{"zero5",   1'b1, 2,   1, 0,  1,  0,    8};
`else
    vecs[0] = '{"good4",   1'b0, 0,   0, 1, 15, 15, 1024};
    vecs[1] = '{"bit0_4",  1'b0, 1, 128, 0, 15, 15, 1024};
    vecs[2] = '{"zero4",   1'b0, 2, 240, 0, 15, 15, 1024};
    vecs[3] = '{"zero5",   1'b1, 2, 255, 0, 31, 31, 4096};
`endif

    // Reset, then sit idle for 10 cycles without start.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", int'(if4.busy), 0);
    chk("idle_done", int'(if4.done), 0);
    chk("idle_pass", int'(if4.pass), 0);
    chk("idle_a",    int'(if4.a), 0);
    chk("idle_b",    int'(if4.b), 0);
    chk("idle_err",  int'(if4.err_count), 0);

    // Table of full sweeps.
    for (int i = 0; i < 4; i++) begin
      do_sweep(vecs[i], 0);
    end

    // A start pulse 50 cycles into a sweep must not disturb it.
    begin
      sweep_t s;
      s      = vecs[0];
      s.name = "restart50";
      do_sweep(s, 50);
    end

    // Mid-sweep reset with a faulty XOR, then a fresh clean sweep.
    fault_mode = 1;
    @(negedge clk);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      if (if4.busy) cyc++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", int'(if4.busy), 0);
    chk("rst_done", int'(if4.done), 0);
    chk("rst_err",  int'(if4.err_count), 0);
    chk("rst_a",    int'(if4.a), 0);
    repeat (5) @(negedge clk);
    chk("rst_stay_idle", int'(if4.busy), 0);
    begin
      sweep_t s;
      s      = vecs[0];
      s.name = "after_rst";
      do_sweep(s, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/xor_selftest_ctrl.md
XOR_SELFTEST_CTRL -- requirements
Module: xor_selftest_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the XOR unit under control.
REQ-002 Parameter SETTLE, default 2, range 1..15: wait cycles between applying operands and sampling result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a self-test sweep.
REQ-006 a  output  WIDTH  operand A driven to the XOR unit.
REQ-007 b  output  WIDTH  operand B driven to the XOR unit.
REQ-008 result  input  WIDTH  XOR unit output.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until next accepted start.
REQ-011 pass  output  1  valid while done=1: 1 when err_count=0.
REQ-012 err_count  output  8  number of mismatching vectors, saturating.

Function
REQ-013 FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
REQ-014 IDLE->APPLY on start=1; DONE->APPLY on start=1; start ignored in APPLY/WAIT/CHECK.
REQ-015 On accepted start: vector counter vec (2*WIDTH bits) := 0, err_count := 0, done := 0.
REQ-016 a = vec[WIDTH-1:0], b = vec[2*WIDTH-1:WIDTH], registered; updated on APPLY entry only, held stable through WAIT and CHECK.
REQ-017 APPLY lasts 1 cycle, then WAIT for exactly SETTLE cycles (wait counter), then CHECK for 1 cycle; per-vector latency = SETTLE+2 cycles.
REQ-018 In CHECK: mismatch when result != (a ^ b); on mismatch err_count increments, saturating at 255.
REQ-019 CHECK->APPLY with vec+1 unless vec is all-ones; at all-ones CHECK->DONE (no wrap to 0 is ever applied).
REQ-020 Full sweep with WIDTH=4, SETTLE=2: 256 vectors x 4 cycles = 1024 cycles from start to done.
REQ-021 busy=1 in APPLY, WAIT, CHECK; done=1 only in DONE; pass = done & (err_count==0).
REQ-022 result sampled only in CHECK; X or changes on result outside CHECK have no effect.

Reset
REQ-023 rst_n=0 at a rising edge forces IDLE, vec=0, wait counter=0, a=0, b=0, busy=0, done=0, pass=0, err_count=0.
REQ-024 Reset mid-sweep aborts it; no done pulse; a new start is required.

Configuration
REQ-025 Macro XOR_SELFTEST_STOP_ON_FAIL_EN: when defined, first mismatch in CHECK sets err_count=1 and transitions CHECK->DONE, with a/b holding the failing vector while in DONE.
REQ-026 Without XOR_SELFTEST_STOP_ON_FAIL_EN, sweep always covers all 2^(2*WIDTH) vectors and a/b hold the last vector in DONE.

Structure
REQ-027 Package xor_selftest_pkg holds the state enum and the ERR_MAX=255 constant.
REQ-028 No sub-module; my_xor is instantiated by the integrating top, not inside this block; bench instantiates both.

Verification
REQ-029 Reset then idle 10 cycles, start never asserted -> busy=0, done=0, a=0, b=0, err_count=0.
REQ-030 WIDTH=4, SETTLE=2, correct my_xor, start pulse -> busy high 1024 cycles, done=1, pass=1, err_count=0, a=b=15.
REQ-031 Faulty XOR stub forcing result bit0 to 0 -> 128 mismatches, err_count=128, pass=0 (macro off); err_count=1, a=1, b=0 in DONE (macro on).
REQ-032 Stub returning constant 0 with WIDTH=4 -> 240 mismatches, err_count=240; WIDTH=5 -> err_count saturates at 255.
REQ-033 start pulsed at cycle 50 of a sweep -> ignored, sweep completes at cycle 1024 unchanged.
REQ-034 rst_n low for 1 cycle at cycle 300, then start -> full fresh sweep, done after 1024 cycles, err_count reflects only new sweep.
